// File: rtl/interrupt_controller.sv
// interrupt_controller
// Latches rising edges on up to NUM_SRC peripheral interrupt lines as pending,
// arbitrates among the enabled ones and hands a single interrupt at a time to
// the CPU via int_req / int_en / int_vec. The CPU does not nest interrupts, so
// one source is tracked in service until the CPU pulses int_ret.
//
// Register window (reg_addr):
//   0 CTRL  : bit0 global enable, other bits read 0
//   1 MASK  : per-source enable bits [NUM_SRC-1:0]
//   2 PEND  : pending bits, write 1 to clear
//   3 VBASE : vector base; int_vec = VBASE + (id << VEC_SHIFT), mod 256
//
// Build option: define INTC_ROUND_ROBIN_EN for a rotating-priority arbiter
// (search upward from the last serviced source). Without it index 0 always
// has the highest priority.

module interrupt_controller #(
    parameter int NUM_SRC   = 4,
    parameter int VEC_SHIFT = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               int_ret,
    input  logic [1:0]         reg_addr,
    input  logic               reg_w_en,
    input  logic [7:0]         reg_w_data,
    output logic [7:0]         reg_r_data,
    output logic               int_req,
    output logic [7:0]         int_en,
    output logic [7:0]         int_vec,
    output logic               busy,
    output logic [2:0]         active_id
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic               ctrl_reg, ctrl_next;
    logic [NUM_SRC-1:0] mask_reg, mask_next;
    logic [NUM_SRC-1:0] pend_reg, pend_next;
    logic [7:0]         vbase_reg, vbase_next;
    logic [NUM_SRC-1:0] irq_prev_reg;

    logic               int_req_reg, int_req_next;
    logic [7:0]         int_vec_reg, int_vec_next;
    logic [2:0]         active_id_reg, active_id_next;

    // Decoded write strobes
    logic wr_ctrl, wr_mask, wr_pend, wr_vbase;

    // Edge detection and arbitration
    logic [NUM_SRC-1:0] irq_edge;
    logic [NUM_SRC-1:0] req_vec;
    logic [NUM_SRC-1:0] grant_clr;
    logic [NUM_SRC-1:0] abort_set;
    logic [NUM_SRC-1:0] w1c_clr;
    logic [2:0]         win_idx;
    logic               win_valid;
    logic               grant;
    logic               abort;
    logic               take;

    // 8-bit zero-padded views for the register read mux
    logic [7:0] mask_view;
    logic [7:0] pend_view;

    assign wr_ctrl  = reg_w_en && (reg_addr == 2'd0);
    assign wr_mask  = reg_w_en && (reg_addr == 2'd1);
    assign wr_pend  = reg_w_en && (reg_addr == 2'd2);
    assign wr_vbase = reg_w_en && (reg_addr == 2'd3);

    // A line high at reset release counts as an edge because the history resets to 0
    assign irq_edge = irq_src & ~irq_prev_reg;
    assign req_vec  = pend_reg & mask_reg;

    // Grant only from IDLE; in REQ the CPU sees int_en and either takes it or we abort
    assign grant = (state_reg == ST_IDLE) && ctrl_reg && win_valid;
    assign take  = (state_reg == ST_REQ) && ctrl_reg;
    assign abort = (state_reg == ST_REQ) && !ctrl_reg;

    assign ctrl_next  = wr_ctrl  ? reg_w_data[0] : ctrl_reg;
    assign vbase_next = wr_vbase ? reg_w_data    : vbase_reg;

    genvar gi;

    // Per-source pending/mask update: edge and abort re-set beat any clear
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign grant_clr[gi] = grant && (win_idx == 3'(gi));
            assign abort_set[gi] = abort && (active_id_reg == 3'(gi));
            assign w1c_clr[gi]   = wr_pend && reg_w_data[gi];
            assign pend_next[gi] = (pend_reg[gi] & ~w1c_clr[gi] & ~grant_clr[gi])
                                 | irq_edge[gi] | abort_set[gi];
            assign mask_next[gi] = wr_mask ? reg_w_data[gi] : mask_reg[gi];
        end
    endgenerate

    // Unimplemented source bits read as zero
    generate
        for (gi = 0; gi < 8; gi++) begin : g_view
            if (gi < NUM_SRC) begin : g_live
                assign mask_view[gi] = mask_reg[gi];
                assign pend_view[gi] = pend_reg[gi];
            end else begin : g_zero
                assign mask_view[gi] = 1'b0;
                assign pend_view[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef INTC_ROUND_ROBIN_EN
    localparam logic [2:0] PTR_RESET = 3'(NUM_SRC - 1);

    logic [2:0] rr_ptr_reg, rr_ptr_next;

    // Pointer follows the source actually taken by the CPU; aborted requests leave it alone
    assign rr_ptr_next = take ? active_id_reg : rr_ptr_reg;

    // Last-grant pointer register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_reg <= PTR_RESET;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Rotating priority: pick the requester closest above the last grant, with wrap
    always_comb begin : p_arb
        int best;
        int dist;
        best      = NUM_SRC;
        dist      = 0;
        win_idx   = 3'd0;
        win_valid = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            dist = (i - int'(rr_ptr_reg) - 1 + 2 * NUM_SRC) % NUM_SRC;
            if (req_vec[i] && (dist < best)) begin
                best      = dist;
                win_idx   = 3'(i);
                win_valid = 1'b1;
            end
        end
    end
`else
    // Fixed priority: lowest set index wins (scan downward so the last hit is the lowest)
    always_comb begin : p_arb
        win_idx   = 3'd0;
        win_valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                win_idx   = 3'(i);
                win_valid = 1'b1;
            end
        end
    end
`endif

    // FSM next-state and registered CPU-facing outputs
    always_comb begin
        state_next     = state_reg;
        int_req_next   = 1'b0;
        int_vec_next   = int_vec_reg;
        active_id_next = active_id_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant) begin
                    state_next     = ST_REQ;
                    int_req_next   = 1'b1;
                    active_id_next = win_idx;
                    int_vec_next   = vbase_reg + (8'(win_idx) << VEC_SHIFT);
                end
            end
            ST_REQ: begin
                // int_en low during the request cycle means the CPU never saw it
                state_next = take ? ST_SERVICE : ST_IDLE;
            end
            ST_SERVICE: begin
                if (int_ret) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, configuration and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            ctrl_reg      <= 1'b0;
            mask_reg      <= '0;
            pend_reg      <= '0;
            vbase_reg     <= 8'd0;
            irq_prev_reg  <= '0;
            int_req_reg   <= 1'b0;
            int_vec_reg   <= 8'd0;
            active_id_reg <= 3'd0;
        end else begin
            state_reg     <= state_next;
            ctrl_reg      <= ctrl_next;
            mask_reg      <= mask_next;
            pend_reg      <= pend_next;
            vbase_reg     <= vbase_next;
            irq_prev_reg  <= irq_src;
            int_req_reg   <= int_req_next;
            int_vec_reg   <= int_vec_next;
            active_id_reg <= active_id_next;
        end
    end

    // Register read mux, combinational from reg_addr
    always_comb begin
        reg_r_data = 8'd0;
        case (reg_addr)
            2'd0:    reg_r_data = {7'd0, ctrl_reg};
            2'd1:    reg_r_data = mask_view;
            2'd2:    reg_r_data = pend_view;
            default: reg_r_data = vbase_reg;
        endcase
    end

    assign int_req   = int_req_reg;
    assign int_vec   = int_vec_reg;
    assign active_id = active_id_reg;
    assign int_en    = {7'd0, ctrl_reg};
    assign busy      = (state_reg != ST_IDLE);

endmodule
